correlate_control: RTL and testbench

Sequencer for the time-multiplexed `correlate` datapath. On a start pulse it walks every correlator time-slot (`taddr`) and issues `COUNT` consecutive valid beats per slot. Each slot's beats are framed with `first`/`last`, and `auto` is flagged for the auto-correlation slots. After the last beat it waits for the correlator pipeline to drain, then signals `done`. It sits between the capture/control logic and the correlator's `valid_i`/`first_i`/`last_i`/`auto_i` inputs; `taddr_o` also drives the antenna-pair select mux.

---
 rtl/correlate_control_pkg.sv | 22 ++
 rtl/correlate_control_if.sv | 26 ++
 rtl/correlate_control_slot_counter.sv | 42 ++++
 rtl/correlate_control.sv | 100 ++++++++++
 tb/tb_correlate_control.sv | 125 ++++++++++++
 5 files changed

// File: rtl/correlate_control_pkg.sv
// Shared correlator constants and the sequencer state encoding.
// The TRATE/COUNT/TAUTO defaults are also used by correlate and the capture logic.
package correlate_control_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_TRATE     = 12;
    localparam int DEF_COUNT     = 3;
    localparam int DEF_TAUTO     = DEF_TRATE - 2;
    localparam int DEF_DRAIN_MIN = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/correlate_control_if.sv
// Handshake bundle between capture/control logic and the correlator sequencer.
// master is the requester side; slave is the sequencer.
interface correlate_control_if #(
    parameter int TBITS = 4
);
    logic             start_i;
    logic             stall_i;
    logic             cor_frame_i;
    logic             busy_o;
    logic             done_o;
    logic             valid_o;
    logic             first_o;
    logic             last_o;
    logic             auto_o;
    logic [TBITS-1:0] taddr_o;

    modport master (
        output start_i, stall_i, cor_frame_i,
        input  busy_o, done_o, valid_o, first_o, last_o, auto_o, taddr_o
    );

    modport slave (
        input  start_i, stall_i, cor_frame_i,
        output busy_o, done_o, valid_o, first_o, last_o, auto_o, taddr_o
    );
endinterface

// File: rtl/correlate_control_slot_counter.sv
// Two-level beat/slot counter. Holds the position of the next beat to issue;
// first/last/wrap decode that position.
module slot_counter #(
    parameter int TRATE = 12,
    parameter int TBITS = 4,
    parameter int COUNT = 3,
    parameter int CBITS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [TBITS-1:0] o_taddr,
    output logic             o_first,
    output logic             o_last,
    output logic             o_wrap
);
    localparam logic [CBITS-1:0] BEAT_MAX = CBITS'(COUNT - 1);
    localparam logic [TBITS-1:0] SLOT_MAX = TBITS'(TRATE - 1);

    logic [CBITS-1:0] r_beat;
    logic [TBITS-1:0] r_taddr;

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_beat  <= '0;
            r_taddr <= '0;
        end else if (i_en) begin
            if (o_last) begin
                r_beat  <= '0;
                r_taddr <= o_wrap ? '0 : r_taddr + 1'b1;
            end else begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    assign o_taddr = r_taddr;
    assign o_first = (r_beat == '0);
    assign o_last  = (r_beat == BEAT_MAX);
    assign o_wrap  = o_last && (r_taddr == SLOT_MAX);
endmodule

// File: rtl/correlate_control.sv
// Frame sequencer for the time-multiplexed correlator: walks every slot issuing
// COUNT framed beats per slot, then waits for the correlator pipeline to drain.
module correlate_control
    import correlate_control_pkg::*;
#(
    parameter int TRATE     = DEF_TRATE,
    parameter int TBITS     = 4,
    parameter int COUNT     = DEF_COUNT,
    parameter int CBITS     = 2,
    parameter int TAUTO     = DEF_TAUTO,
    parameter int DRAIN_MIN = DEF_DRAIN_MIN
) (
    input  logic               clock,
    input  logic               reset,
    correlate_control_if.slave bus
);
    localparam int               DW      = cnt_bits(DRAIN_MIN + 1);
    localparam logic [DW-1:0]    DMAX    = DW'(DRAIN_MIN);
    localparam logic [TBITS-1:0] TAUTO_T = TBITS'(TAUTO);

    state_t           r_state, w_next;
    logic             w_emit, w_clr, w_first, w_last, w_wrap;
    logic [TBITS-1:0] w_taddr;
    logic [DW-1:0]    r_dcnt;
    logic             r_busy, r_done, r_valid, r_first, r_last, r_auto;
    logic [TBITS-1:0] r_taddr;

    // The counter sits at zero outside RUN, so a start beat issues slot 0 / beat 0.
    assign w_clr = !w_emit && (r_state != S_RUN);

    slot_counter #(
        .TRATE(TRATE), .TBITS(TBITS), .COUNT(COUNT), .CBITS(CBITS)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_emit),
        .o_taddr(w_taddr),
        .o_first(w_first),
        .o_last (w_last),
        .o_wrap (w_wrap)
    );

    always_comb begin
        w_next = r_state;
        w_emit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_emit = !bus.stall_i;
                    w_next = (w_emit && w_wrap) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                w_emit = !bus.stall_i;
                if (w_emit && w_wrap) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_dcnt == DMAX && !bus.cor_frame_i) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_auto  <= 1'b0;
            r_taddr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != S_DRAIN)  r_dcnt <= '0;
            else if (r_dcnt != DMAX) r_dcnt <= r_dcnt + 1'b1;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
            r_valid <= w_emit;
            r_first <= w_emit && w_first;
            r_last  <= w_emit && w_last;
            r_auto  <= w_emit && (w_taddr >= TAUTO_T);
            // A stalled cycle keeps showing the last issued slot.
            if (w_emit)                r_taddr <= w_taddr;
            else if (w_next != S_RUN)  r_taddr <= '0;
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.done_o  = r_done;
    assign bus.valid_o = r_valid;
    assign bus.first_o = r_first;
    assign bus.last_o  = r_last;
    assign bus.auto_o  = r_auto;
    assign bus.taddr_o = r_taddr;
endmodule

// File: tb/tb_correlate_control.sv
// Directed bench for correlate_control: default-parameter frames plus a
// COUNT=1/TRATE=4 corner instance.
module tb_correlate_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    correlate_control_if #(.TBITS(4)) bus ();
    correlate_control_if #(.TBITS(2)) bus2 ();

    correlate_control #(
        .TRATE(12), .TBITS(4), .COUNT(3), .CBITS(2), .TAUTO(10), .DRAIN_MIN(2)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus.slave)
    );

    correlate_control #(
        .TRATE(4), .TBITS(2), .COUNT(1), .CBITS(1), .TAUTO(2), .DRAIN_MIN(2)
    ) dut2 (
        .clock(clock), .reset(reset), .bus(bus2.slave)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    cur_t = 0;
    string cur_ph = "init";

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s t=%0d: got %0d want %0d", cur_ph, tag, cur_t, act, exp);
        end
    endtask

    task automatic chk_flags(input logic busy, input logic done, input logic valid,
                             input logic first, input logic last, input logic aut);
        chk("busy",  32'(bus.busy_o),  32'(busy));
        chk("done",  32'(bus.done_o),  32'(done));
        chk("valid", 32'(bus.valid_o), 32'(valid));
        chk("first", 32'(bus.first_o), 32'(first));
        chk("last",  32'(bus.last_o),  32'(last));
        chk("auto",  32'(bus.auto_o),  32'(aut));
    endtask

    // Frame with start at t=0; stall high for L cycles from cycle S; cor_frame
    // high on cycles < R; extra starts at x1/x2; reset pulsed at cycle ab.
    task automatic run_frame(input string ph, input int L, input int S, input int R,
                             input int x1, input int x2, input int ab);
        int last_c, d, b, t_end;
        bit v;
        cur_ph = ph;
        last_c = 36 + L;
        d      = (last_c + 3 > R + 1) ? last_c + 3 : R + 1;
        t_end  = (ab >= 0) ? ab + 4 : d + 2;
        for (int t = 0; t <= t_end; t++) begin
            @(posedge clock); #1;
            bus.start_i     = (t == 0) || (t == x1) || (t == x2);
            bus.stall_i     = (L > 0) && (t >= S) && (t < S + L);
            bus.cor_frame_i = (t < R);
            reset           = (ab >= 0) && (t == ab);
            @(negedge clock);
            cur_t = t;
            if (ab >= 0 && t > ab) begin
                chk_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("taddr", 32'(bus.taddr_o), 32'd0);
            end else begin
                if (t == 0)                                b = -1;
                else if (L == 0 || t <= S)                 b = t - 1;
                else if (t <= S + L)                       b = -1;
                else                                       b = t - 1 - L;
                v = (b >= 0) && (b < 36);
                chk_flags((t >= 1) && (t <= d), (t == d), v,
                          v && (b % 3 == 0), v && (b % 3 == 2), v && (b / 3 >= 10));
                if (v)                        chk("taddr", 32'(bus.taddr_o), 32'(b / 3));
                else if (t == 0 || t > last_c) chk("taddr", 32'(bus.taddr_o), 32'd0);
            end
        end
        @(posedge clock); #1;
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.cor_frame_i = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0;  bus.stall_i = 1'b0;  bus.cor_frame_i = 1'b0;
        bus2.start_i = 1'b0; bus2.stall_i = 1'b0; bus2.cor_frame_i = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cur_ph = "reset";
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("taddr",  32'(bus.taddr_o),  32'd0);
        chk("busy2",  32'(bus2.busy_o),  32'd0);
        chk("valid2", 32'(bus2.valid_o), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        run_frame("basic",   0, 0,  0, -1, -1, -1);
        run_frame("stall",   5, 5,  0, -1, -1, -1);
        run_frame("drain",   0, 0, 45, -1, -1, -1);
        run_frame("ignstart",0, 0,  0, 10, 38, -1);
        run_frame("midrst",  0, 0,  0, -1, -1, 20);
        run_frame("restart", 0, 0,  0, -1, -1, -1);

        cur_ph = "count1";
        for (int t = 0; t <= 9; t++) begin
            @(posedge clock); #1;
            bus2.start_i = (t == 0);
            @(negedge clock);
            cur_t = t;
            chk("busy2",  32'(bus2.busy_o),  32'((t >= 1) && (t <= 7)));
            chk("done2",  32'(bus2.done_o),  32'(t == 7));
            chk("valid2", 32'(bus2.valid_o), 32'((t >= 1) && (t <= 4)));
            chk("first2", 32'(bus2.first_o), 32'((t >= 1) && (t <= 4)));
            chk("last2",  32'(bus2.last_o),  32'((t >= 1) && (t <= 4)));
            chk("auto2",  32'(bus2.auto_o),  32'((t >= 3) && (t <= 4)));
            chk("taddr2", 32'(bus2.taddr_o), 32'((t >= 1 && t <= 4) ? t - 1 : 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
